bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_if.sv | 20 ++
 rtl/bus_arbiter_rr_pick4.sv | 23 ++
 rtl/bus_arbiter.sv | 93 +++++++++
 tb/tb_bus_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: bus source indices and FSM state encoding.
package bus_arbiter_pkg;

    localparam int NUM_SRC = 24;

    localparam logic [4:0] R0  = 5'd0,  R1  = 5'd1,  R2  = 5'd2,  R3  = 5'd3;
    localparam logic [4:0] R4  = 5'd4,  R5  = 5'd5,  R6  = 5'd6,  R7  = 5'd7;
    localparam logic [4:0] R8  = 5'd8,  R9  = 5'd9,  R10 = 5'd10, R11 = 5'd11;
    localparam logic [4:0] R12 = 5'd12, R13 = 5'd13, R14 = 5'd14, R15 = 5'd15;
    localparam logic [4:0] HI  = 5'd16, LO  = 5'd17, ZHI = 5'd18, ZLO = 5'd19;
    localparam logic [4:0] PC  = 5'd20, MDR = 5'd21, INPORT = 5'd22, CSIGN = 5'd23;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic src_in_range(input logic [4:0] idx);
        return idx < 5'(NUM_SRC);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface bus_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [19:0] src_sel;
    logic [3:0]  gnt;
    logic [23:0] Encoder_signals;
    logic        bus_valid;
    logic        src_err;

    modport master (
        output req, lock, src_sel,
        input  gnt, Encoder_signals, bus_valid, src_err
    );

    modport slave (
        input  req, lock, src_sel,
        output gnt, Encoder_signals, bus_valid, src_err
    );
endinterface

// File: rtl/bus_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping mod 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win,
    output logic       any
);
    logic [1:0] cand;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        win  = 2'd0;
        any  = 1'b0;
        cand = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                win = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with lock-based holding and one-hot source drive.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic          clock,
    input  logic          clear,
    bus_arbiter_if.slave  bus
);
    arb_state_t  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  search_ptr, win;
    logic        any_req, hold;
    logic [3:0]  gnt_d;
    logic [23:0] enc_d;
    logic        valid_d, err_d;

    // On release the search starts just past the outgoing owner, which also
    // puts that owner last in line after a forced HOLD_MAX release.
    assign search_ptr = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (search_ptr),
        .win (win),
        .any (any_req)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hold    = (state_q == GRANT) && bus.lock[owner_q] && bus.req[owner_q]
                  && (({27'd0, cnt_q} + 32'd1) < 32'(HOLD_MAX));
        if (hold) begin
            cnt_d = cnt_q + 5'd1;
        end else begin
            if (state_q == GRANT) ptr_d = owner_q + 2'd1;
            if (any_req) begin
                state_d = GRANT;
                owner_d = win;
                cnt_d   = 5'd0;
                idx_d   = bus.src_sel[5*int'(win) +: 5];
            end else begin
                state_d = IDLE;
            end
        end

        gnt_d   = '0;
        enc_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (state_d == GRANT) begin
            gnt_d = 4'b0001 << owner_d;
            if (src_in_range(idx_d)) begin
                enc_d   = 24'd1 << idx_d;
                valid_d = 1'b1;
            end else begin
                err_d = (cnt_d == 5'd0);
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q             <= IDLE;
            owner_q             <= 2'd0;
            ptr_q               <= 2'd0;
            cnt_q               <= 5'd0;
            idx_q               <= 5'd0;
            bus.gnt             <= '0;
            bus.Encoder_signals <= '0;
            bus.bus_valid       <= 1'b0;
            bus.src_err         <= 1'b0;
        end else begin
            state_q             <= state_d;
            owner_q             <= owner_d;
            ptr_q               <= ptr_d;
            cnt_q               <= cnt_d;
            idx_q               <= idx_d;
            bus.gnt             <= gnt_d;
            bus.Encoder_signals <= enc_d;
            bus.bus_valid       <= valid_d;
            bus.src_err         <= err_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int HOLD_MAX = 16;

    logic clock;
    logic clear;
    bus_arbiter_if bif ();

    bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the bus, for how long, and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_idx;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_idx = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic [19:0] s);
        bit keep;
        keep = m_busy && l[m_owner] && r[m_owner] && (m_cnt + 1 < HOLD_MAX);
        if (keep) begin
            m_cnt++;
        end else begin
            if (m_busy) m_ptr = (m_owner + 1) % 4;
            m_busy = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!m_busy && r[i]) begin
                    m_busy  = 1;
                    m_owner = i;
                    m_cnt   = 0;
                    m_idx   = int'(s[5*i +: 5]);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [23:0] ee,
                         input logic ev, input logic er);
        tests += 4;
        assert (bif.gnt === eg) else begin
            fails++;
            $error("FAIL %s gnt got %b want %b", tag, bif.gnt, eg);
        end
        assert (bif.Encoder_signals === ee) else begin
            fails++;
            $error("FAIL %s enc got %h want %h", tag, bif.Encoder_signals, ee);
        end
        assert (bif.bus_valid === ev) else begin
            fails++;
            $error("FAIL %s bus_valid got %b want %b", tag, bif.bus_valid, ev);
        end
        assert (bif.src_err === er) else begin
            fails++;
            $error("FAIL %s src_err got %b want %b", tag, bif.src_err, er);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  eg;
        logic [23:0] ee;
        logic        ev, er;
        eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        ev = m_busy && (m_idx < NUM_SRC);
        ee = ev ? (24'd1 << m_idx) : 24'd0;
        er = m_busy && (m_idx >= NUM_SRC) && (m_cnt == 0);
        check(tag, eg, ee, ev, er);
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic [19:0] s,
                         input string tag);
        bif.req = r; bif.lock = l; bif.src_sel = s;
        @(posedge clock);
        model_step(r, l, s);
        @(negedge clock);
        check_model(tag);
    endtask

    task automatic async_clear(input string tag);
        #2 clear = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        check({tag, "_zero"}, 4'b0, 24'd0, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        logic [19:0] s;
        logic [3:0]  r, l;
        clear = 1'b1;
        bif.req = '0; bif.lock = '0; bif.src_sel = '0;
        model_reset();
        @(negedge clock);
        check("reset", 4'b0, 24'd0, 1'b0, 1'b0);
        clear = 1'b0;

        // Single unlocked request driving PC.
        s = {15'd0, PC};
        cycle(4'b0001, 4'b0000, s, "basic_grant");
        check("basic_lit", 4'b0001, 24'd1 << 20, 1'b1, 1'b0);
        cycle(4'b0000, 4'b0000, s, "basic_release");
        check("basic_idle", 4'b0000, 24'd0, 1'b0, 1'b0);

        // All four requesting, no lock: back-to-back rotation from 0.
        async_clear("rr_clr");
        s = {R3, R2, R1, R0};
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1111, 4'b0000, s, $sformatf("rr_%0d", k));
            check($sformatf("rr_lit_%0d", k), 4'b0001 << k, 24'd1 << k, 1'b1, 1'b0);
        end
        cycle(4'b0000, 4'b0000, s, "rr_idle");

        // Requester 0 locks until HOLD_MAX, then requester 1 takes over.
        async_clear("hold_clr");
        s = {R3, R2, HI, LO};
        for (int k = 0; k < HOLD_MAX + 1; k++) begin
            cycle(4'b0011, 4'b0001, s, $sformatf("hold_%0d", k));
            check($sformatf("hold_lit_%0d", k), (k < HOLD_MAX) ? 4'b0001 : 4'b0010,
                  (k < HOLD_MAX) ? (24'd1 << LO) : (24'd1 << HI), 1'b1, 1'b0);
        end
        cycle(4'b0000, 4'b0000, s, "hold_idle");

        // Out-of-range source index on requester 2.
        s = {5'd0, 5'd25, 5'd0, 5'd0};
        cycle(4'b0100, 4'b0000, s, "bad_src");
        check("bad_src_lit", 4'b0100, 24'd0, 1'b0, 1'b1);
        cycle(4'b0000, 4'b0000, s, "bad_src_idle");
        check("bad_src_after", 4'b0000, 24'd0, 1'b0, 1'b0);

        // src_sel changes mid-hold must not move the source drive.
        for (int k = 0; k < 8; k++) begin
            s = {5'd0, 5'd0, (k < 3) ? R5 : R7, 5'd0};
            cycle(4'b0010, 4'b0010, s, $sformatf("capture_%0d", k));
            check($sformatf("capture_lit_%0d", k), 4'b0010, 24'd1 << 5, 1'b1, 1'b0);
        end
        cycle(4'b0000, 4'b0000, s, "capture_idle");

        // Clear in the middle of requester 3's lock, then re-grant from ptr 0.
        s = {MDR, 5'd0, 5'd0, 5'd0};
        for (int k = 0; k < 3; k++) cycle(4'b1000, 4'b1000, s, $sformatf("midlock_%0d", k));
        async_clear("midlock_clr");
        cycle(4'b1000, 4'b0000, s, "after_clr");
        check("after_clr_lit", 4'b1000, 24'd1 << 21, 1'b1, 1'b0);
        cycle(4'b1111, 4'b0000, {R3, R2, R1, R0}, "after_clr_rr");
        check("after_clr_rr_lit", 4'b0001, 24'd1, 1'b1, 1'b0);

        // Random traffic, lock biased high so HOLD_MAX expiry occurs.
        for (int n = 0; n < 600; n++) begin
            r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            s = 20'($urandom);
            if ($urandom_range(0, 79) == 0) async_clear($sformatf("rnd_clr_%0d", n));
            else cycle(r, l, s, $sformatf("rnd_%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
